// File: rtl/rom_msg_reader_pkg.sv
// Shared types and constants for the ROM message reader.
package rom_msg_reader_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    localparam logic [7:0] TERM_CHAR_DEF = 8'h00;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_NUL     = 8'h00;

endpackage

// File: rtl/rom_msg_reader_if.sv
// ROM fetch port plus valid/ready byte stream toward the character sink.
interface rom_msg_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output rom_addr, tx_data, tx_valid, input rom_data, tx_ready);
    modport slave  (input rom_addr, tx_data, tx_valid, output rom_data, tx_ready);
endinterface

// File: rtl/rom_msg_reader.sv
// Streams a terminator-ended message from a combinational ROM, one byte per transfer.
// ROM_MSG_READER_LOOP_EN adds a stop input and repeats the message until stop is seen in DONE.
module rom_msg_reader
    import rom_msg_reader_pkg::*;
#(
    parameter int                 ADDR_W    = 4,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  TERM_CHAR = DATA_W'(TERM_CHAR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef ROM_MSG_READER_LOOP_EN
    input  logic              stop,
`endif
    rom_msg_reader_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   char_count
);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [DATA_W-1:0]  data_q, data_nxt;
    logic               valid_q, valid_nxt;
    logic [ADDR_W:0]    count_q, count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            count_q <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        count_nxt = count_q;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = '0;
                    count_nxt = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (bus.rom_data == TERM_CHAR) begin
                    state_nxt = DONE;
                end else begin
                    data_nxt  = bus.rom_data;
                    valid_nxt = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (valid_q && bus.tx_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = count_q + 1'b1;
                    // Last ROM slot ends the message; the address never wraps.
                    if (&addr_q) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt  = addr_q + 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
`ifdef ROM_MSG_READER_LOOP_EN
                if (!stop) begin
                    addr_nxt  = '0;
                    count_nxt = '0;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rom_addr = addr_q;
    assign bus.tx_data  = data_q;
    assign bus.tx_valid = valid_q;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign char_count   = count_q;

endmodule

// File: tb/tb_rom_msg_reader.sv
// Scoreboard bench for rom_msg_reader; ROM modelled as a combinational array.
module tb_rom_msg_reader;
    import rom_msg_reader_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   char_count;
`ifdef ROM_MSG_READER_LOOP_EN
    logic              stop;
`endif

    logic [DATA_W-1:0] rom [16];
    logic [DATA_W-1:0] exp_q [$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                acc_cnt = 0;
    int                done_cnt = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    rom_msg_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    assign bus.rom_data = rom[bus.rom_addr];

    rom_msg_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef ROM_MSG_READER_LOOP_EN
        .stop       (stop),
`endif
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .char_count (char_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted byte must match the next expected one in order.
    always @(negedge clk) begin
        if (prev_stall && rst_n) begin
            chk("hold_valid", {31'd0, bus.tx_valid}, 1);
            chk("hold_data", {24'd0, bus.tx_data}, {24'd0, prev_data});
        end
        prev_stall <= rst_n && bus.tx_valid && !bus.tx_ready;
        prev_data  <= bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) begin
            chk("q_nonempty", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) chk("byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
            acc_cnt <= acc_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic load_student();
        logic [63:0] s;
        s = "STUDENT ";
        for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? s[63-8*i -: 8] : ASCII_NUL;
    endtask

    task automatic push_student();
        for (int i = 0; i < 8; i++) exp_q.push_back(rom[i]);
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
        chk("done_seen", {31'd0, cyc >= 0}, 1);
    endtask

    initial begin
        int cyc;
        int d0;
        int a0;
        int found;
        rst_n = 1'b0;
        start = 1'b0;
        bus.tx_ready = 1'b1;
`ifdef ROM_MSG_READER_LOOP_EN
        stop = 1'b1;
`endif
        load_student();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", {28'd0, bus.rom_addr}, 0);
        chk("rst_data", {24'd0, bus.tx_data}, 0);
        chk("rst_valid", {31'd0, bus.tx_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_count", {27'd0, char_count}, 0);
        rst_n = 1'b1;

        // 1: basic message, latency and throughput
        push_student();
        pulse_start();
        chk("t1_fetch_busy", {31'd0, busy}, 1);
        chk("t1_fetch_valid", {31'd0, bus.tx_valid}, 0);
        @(posedge clk) #1;
        chk("t1_first_valid", {31'd0, bus.tx_valid}, 1);
        chk("t1_first_data", {24'd0, bus.tx_data}, 32'h53);
        wait_done(40, cyc);
        chk("t1_done_latency", cyc, 16);
        chk("t1_count", {27'd0, char_count}, 8);
        chk("t1_term_addr", {28'd0, bus.rom_addr}, 8);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 0);
        chk("t1_idle", {31'd0, busy}, 0);
        chk("t1_q_empty", exp_q.size(), 0);

        // 2: backpressure on 'U'
        push_student();
        pulse_start();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk) #1;
            if (bus.tx_valid && bus.tx_data == 8'h55) begin
                found = 1;
                break;
            end
        end
        chk("t2_found_u", found, 1);
        bus.tx_ready = 1'b0;
        repeat (5) begin
            @(posedge clk) #1;
            chk("t2_stall_valid", {31'd0, bus.tx_valid}, 1);
            chk("t2_stall_data", {24'd0, bus.tx_data}, 32'h55);
        end
        bus.tx_ready = 1'b1;
        wait_done(40, cyc);
        chk("t2_count", {27'd0, char_count}, 8);
        @(negedge clk);
        chk("t2_q_empty", exp_q.size(), 0);

        // 3: empty message
        rom[0] = ASCII_NUL;
        pulse_start();
        chk("t3_n1_done", {31'd0, done}, 0);
        chk("t3_n1_busy", {31'd0, busy}, 1);
        @(posedge clk) #1;
        chk("t3_n2_done", {31'd0, done}, 1);
        chk("t3_n2_valid", {31'd0, bus.tx_valid}, 0);
        chk("t3_count", {27'd0, char_count}, 0);
        @(posedge clk) #1;
        chk("t3_after_done", {31'd0, done}, 0);
        chk("t3_after_busy", {31'd0, busy}, 0);

        // 4: full ROM, no terminator
        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'h41 + 8'(i);
            exp_q.push_back(rom[i]);
        end
        pulse_start();
        wait_done(80, cyc);
        chk("t4_count", {27'd0, char_count}, 16);
        chk("t4_no_wrap", {28'd0, bus.rom_addr}, 15);
        @(negedge clk);
        chk("t4_idle", {31'd0, busy}, 0);
        chk("t4_q_empty", exp_q.size(), 0);

        // 5: start while busy / in DONE is ignored; then reset mid-message
        load_student();
        push_student();
        d0 = done_cnt;
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        wait_done(40, cyc);
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        chk("t5_done_start_busy", {31'd0, busy}, 0);
        @(posedge clk) #1;
        chk("t5_still_idle", {31'd0, busy}, 0);
        chk("t5_one_done", done_cnt - d0, 1);
        chk("t5_q_empty", exp_q.size(), 0);
        chk("t5_count", {27'd0, char_count}, 8);

        push_student();
        a0 = acc_cnt;
        pulse_start();
        for (int i = 0; i < 40 && (acc_cnt - a0) < 3; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t5_three_bytes", acc_cnt - a0, 3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_addr", {28'd0, bus.rom_addr}, 0);
        chk("t5_rst_data", {24'd0, bus.tx_data}, 0);
        chk("t5_rst_valid", {31'd0, bus.tx_valid}, 0);
        chk("t5_rst_busy", {31'd0, busy}, 0);
        chk("t5_rst_count", {27'd0, char_count}, 0);
        exp_q.delete();
        @(posedge clk) #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_resume_busy", {31'd0, busy}, 0);
        chk("t5_no_resume_valid", {31'd0, bus.tx_valid}, 0);

`ifdef ROM_MSG_READER_LOOP_EN
        // 6: looping until stop
        stop = 1'b0;
        push_student();
        push_student();
        d0 = done_cnt;
        pulse_start();
        wait_done(40, cyc);
        chk("t6_pass1_count", {27'd0, char_count}, 8);
        @(posedge clk) #1;
        chk("t6_looping", {31'd0, busy}, 1);
        chk("t6_restart_addr", {28'd0, bus.rom_addr}, 0);
        chk("t6_restart_count", {27'd0, char_count}, 0);
        stop = 1'b1;
        wait_done(40, cyc);
        chk("t6_pass2_count", {27'd0, char_count}, 8);
        @(negedge clk);
        chk("t6_stopped", {31'd0, busy}, 0);
        chk("t6_two_dones", done_cnt - d0, 2);
        chk("t6_q_empty", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
